// File: rtl/pcc_pkg.sv
// Shared types and helpers for the streaming popcount comparator.
// Holds the FSM state enum, accumulator-width helper and generic popcount.
package pcc_pkg;

  typedef enum logic [1:0] {
    ST_ACC,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  localparam int PC_MAX_W = 64;

  function automatic int acc_width(
    input int n_pos,
    input int n_neg,
    input int max_beats
  );
    int w;
    w = (n_pos > n_neg) ? n_pos : n_neg;
    return $clog2(w * max_beats + 1) + 2;
  endfunction

  function automatic int unsigned popcount(
    input logic [PC_MAX_W-1:0] v
  );
    int unsigned c;
    c = 0;
    for (int i = 0; i < PC_MAX_W; i++) begin
      c = c + 32'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/pcc_popcount.sv
// Combinational popcount of one vote vector, zero-extended to OUT_W.
// Build option PCC_APPROX_EN halves the count (drops the LSB).
module pcc_popcount
  import pcc_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int OUT_W = 9
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [OUT_W-1:0] cnt_o
);

  logic [PC_MAX_W-1:0] vec_ext;
  int unsigned         pc;

  assign vec_ext = PC_MAX_W'(vec_i);
  assign pc      = popcount(vec_ext);

`ifdef PCC_APPROX_EN
  assign cnt_o = OUT_W'(pc >> 1);
`else
  assign cnt_o = OUT_W'(pc);
`endif

endmodule

// File: rtl/pcc_stream_acc.sv
// Streaming popcount-difference accumulator with thresholded decision.
// Optional build macro PCC_APPROX_EN selects halved per-beat counts.
module pcc_stream_acc
  import pcc_pkg::*;
#(
  parameter int N_POS     = 2,
  parameter int N_NEG     = 6,
  parameter int MAX_BEATS = 16,
  localparam int ACC_W    = acc_width(N_POS, N_NEG, MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_POS-1:0] in_pos,
  input  logic [N_NEG-1:0] in_neg,
  input  logic             in_last,
  input  logic [ACC_W-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_decision,
  output logic [ACC_W-1:0] out_diff,
  output logic             out_trunc
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_e            state_q;
  logic              in_ready_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              s1_vld_q;
  logic              s1_first_q;
  logic              s1_trunc_q;
  logic [ACC_W-1:0]  s1_pos_q;
  logic [ACC_W-1:0]  s1_neg_q;
  logic [ACC_W-1:0]  thresh_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W-1:0]  pos_cnt;
  logic [ACC_W-1:0]  neg_cnt;
  logic              out_valid_q;
  logic              out_dec_q;
  logic              out_trunc_q;
  logic [ACC_W-1:0]  out_diff_q;
  logic              accept;
  logic              first;
  logic              end_beat;

  pcc_popcount #(.WIDTH(N_POS), .OUT_W(ACC_W)) u_pc_pos (
    .vec_i (in_pos),
    .cnt_o (pos_cnt)
  );

  pcc_popcount #(.WIDTH(N_NEG), .OUT_W(ACC_W)) u_pc_neg (
    .vec_i (in_neg),
    .cnt_o (neg_cnt)
  );

  assign accept   = in_valid && in_ready_q;
  assign first    = (beat_cnt_q == '0);
  assign end_beat = in_last || (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  // Final value is visible here on the DRAIN edge, one cycle ahead of acc_q.
  assign acc_d = (s1_first_q ? '0 : acc_q) + s1_pos_q - s1_neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_trunc_q <= 1'b0;
      s1_pos_q   <= '0;
      s1_neg_q   <= '0;
      thresh_q   <= '0;
      acc_q      <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_pos_q   <= pos_cnt;
        s1_neg_q   <= neg_cnt;
        s1_first_q <= first;
        s1_trunc_q <= end_beat && !in_last;
        if (first) thresh_q <= thresh;
      end
      if (s1_vld_q) acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      in_ready_q  <= 1'b1;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_dec_q   <= 1'b0;
      out_trunc_q <= 1'b0;
      out_diff_q  <= '0;
    end else begin
      unique case (state_q)
        ST_ACC: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            if (end_beat) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          out_diff_q  <= acc_d;
          out_dec_q   <= $signed(acc_d) >= $signed(thresh_q);
          out_trunc_q <= s1_trunc_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_ACC;
          end
        end
        default: begin
          state_q    <= ST_ACC;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_decision = out_dec_q;
  assign out_diff     = out_diff_q;
  assign out_trunc    = out_trunc_q;

endmodule

// File: tb/tb_pcc_stream_acc.sv
// Scoreboard bench for pcc_stream_acc: directed frames, decoupled monitor.
// Expected values cover both the exact and the PCC_APPROX_EN build.
module tb_pcc_stream_acc;
  import pcc_pkg::*;

  localparam int ACC_W = acc_width(2, 6, 16);
`ifdef PCC_APPROX_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_pos = '0;
  logic [5:0] in_neg = '0;
  logic in_last = 1'b0;
  logic [ACC_W-1:0] thresh = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic out_decision;
  logic [ACC_W-1:0] out_diff;
  logic out_trunc;

  typedef struct packed {
    logic [ACC_W-1:0] diff;
    logic             dec;
    logic             trunc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int vectors = 0;
  int errors = 0;

  pcc_stream_acc dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pos       (in_pos),
    .in_neg       (in_neg),
    .in_last      (in_last),
    .thresh       (thresh),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_decision (out_decision),
    .out_diff     (out_diff),
    .out_trunc    (out_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sdiff(input logic [ACC_W-1:0] v);
    return int'($signed(v));
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_result: got diff %0d, expected no result",
                 sdiff(out_diff));
      end else begin
        mon_e = sb.pop_front();
        check("diff", sdiff(out_diff), sdiff(mon_e.diff));
        check("decision", int'(out_decision), int'(mon_e.dec));
        check("trunc", int'(out_trunc), int'(mon_e.trunc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic dec, input logic tr);
    sb.push_back('{diff: ACC_W'(d), dec: dec, trunc: tr});
  endtask

  task automatic send(input logic [1:0] p, input logic [5:0] n,
                      input logic l, input int th);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_pos   = p;
    in_neg   = n;
    in_last  = l;
    thresh   = ACC_W'(th);
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) begin
      vectors++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0, expected 1");
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(in_ready && !out_valid) && w < 40) begin
      tick();
      w++;
    end
    if (w >= 40) begin
      vectors++;
      errors++;
      $display("FAIL idle_timeout: got in_ready %0b, expected 1", in_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_diff", sdiff(out_diff), 0);
    check("rst_out_decision", int'(out_decision), 0);
    check("rst_out_trunc", int'(out_trunc), 0);
    rst_n = 1'b1;
    tick();

    // single beat, latency and ready drop
    push(APPROX ? 0 : -1, APPROX ? 1'b1 : 1'b0, 1'b0);
    send(2'b11, 6'b000111, 1'b1, 0);
    check("lat_ready_low", int'(in_ready), 0);
    check("lat_valid_low", int'(out_valid), 0);
    tick();
    check("lat_valid_high", int'(out_valid), 1);
    wait_idle();

    // three-beat frame
    push(APPROX ? 1 : 2, 1'b1, 1'b0);
    send(2'b11, 6'b000001, 1'b0, 0);
    send(2'b11, 6'b000000, 1'b0, 0);
    send(2'b01, 6'b000011, 1'b1, 0);
    check("multi_ready_drain", int'(in_ready), 0);
    tick();
    check("multi_ready_hold", int'(in_ready), 0);
    wait_idle();

    // tie, then threshold one above
    push(0, 1'b1, 1'b0);
    send(2'b11, 6'b000011, 1'b1, 0);
    wait_idle();
    push(0, 1'b0, 1'b0);
    send(2'b11, 6'b000011, 1'b1, 1);
    wait_idle();

    // negative threshold
    push(APPROX ? -3 : -6, APPROX ? 1'b1 : 1'b0, 1'b0);
    send(2'b00, 6'b111111, 1'b1, -3);
    wait_idle();

    // backpressure
    out_ready = 1'b0;
    push(1, 1'b1, 1'b0);
    send(2'b11, 6'b000001, 1'b1, -2);
    tick();
    check("bp_valid", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid_hold", int'(out_valid), 1);
      check("bp_diff_hold", sdiff(out_diff), 1);
      check("bp_dec_hold", int'(out_decision), 1);
      check("bp_ready_low", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_ready_after", int'(in_ready), 1);
    check("bp_valid_after", int'(out_valid), 0);

    // forced termination at MAX_BEATS
    push(APPROX ? 16 : 32, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) send(2'b11, 6'b000000, 1'b0, 0);
    check("trunc_ready_low", int'(in_ready), 0);
    wait_idle();
    push(APPROX ? 0 : 1, 1'b1, 1'b0);
    send(2'b01, 6'b000000, 1'b1, 0);
    wait_idle();

    // reset mid-frame
    send(2'b11, 6'b000000, 1'b0, 0);
    send(2'b11, 6'b000000, 1'b0, 0);
    rst_n = 1'b0;
    tick();
    check("midrst_ready", int'(in_ready), 1);
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_diff", sdiff(out_diff), 0);
    rst_n = 1'b1;
    tick();
    push(APPROX ? 0 : 1, 1'b1, 1'b0);
    send(2'b01, 6'b000000, 1'b1, 0);
    wait_idle();

    repeat (5) tick();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
